// File: rtl/seq_div_pkg.sv
// seq_div_pkg: state encoding and sizing helpers shared by the sequential divider.
package seq_div_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;
   localparam int WIDTH_DEF = 8;
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction
endpackage

// File: rtl/seq_divider_trial_sub.sv
// trial_sub: ripple-carry a + ~b + 1; borrow is the inverted carry out.
module trial_sub #(
   parameter int N = 9
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] diff,
   output logic         borrow
);
   logic [N:0] c;
   assign c[0] = 1'b1;
   for (genvar i = 0; i < N; i++) begin : g_fa
      assign diff[i] = a[i] ^ ~b[i] ^ c[i];
      assign c[i+1] = (a[i] & ~b[i]) | (c[i] & (a[i] ^ ~b[i]));
   end
   assign borrow = ~c[N];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per clock.
module seq_divider
   import seq_div_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int CW = cnt_width(WIDTH);
   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   p_q, p_d;
   logic [WIDTH-1:0] q_q, q_d, dvs_q, dvs_d;
   logic             zero_q, zero_d;
   logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
   logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
   logic [WIDTH:0]   p_sh, diff;
   logic             borrow;
   // after a restore step P < divisor, so its top bit is never needed again
   logic             unused_msb;
   assign unused_msb = p_q[WIDTH];
   assign p_sh = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
   trial_sub #(.N(WIDTH + 1)) u_sub (
      .a      (p_sh),
      .b      ({1'b0, dvs_q}),
      .diff   (diff),
      .borrow (borrow)
   );
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      q_d     = q_q;
      dvs_d   = dvs_q;
      zero_d  = zero_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      if (state_q == IDLE && start) begin
         dvs_d   = divisor;
         p_d     = '0;
         q_d     = dividend;
         zero_d  = (divisor == '0);
         cnt_d   = CW'(WIDTH - 1);
         state_d = (divisor == '0) ? FIN : RUN;
      end else if (state_q == RUN) begin
         p_d     = borrow ? p_sh : diff;
         q_d     = {q_q[WIDTH-2:0], ~borrow};
         cnt_d   = cnt_q - CW'(1);
         state_d = (cnt_q == '0) ? FIN : RUN;
      end else if (state_q == FIN) begin
         // a zero divisor leaves the untouched dividend in Q
         quo_d   = zero_q ? '1 : q_q;
         rem_d   = zero_q ? q_q : p_q[WIDTH-1:0];
         dbz_d   = zero_q;
         state_d = IDLE;
      end
      done_d = (state_q == FIN);
      busy_d = (state_d != IDLE) || (state_q == FIN);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         p_q     <= '0;
         q_q     <= '0;
         dvs_q   <= '0;
         zero_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         q_q     <= q_d;
         dvs_q   <= dvs_d;
         zero_q  <= zero_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end
   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: timing/arithmetic model plus directed literal checks for seq_divider.
module tb_seq_divider;
   localparam int W = 8;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;
   int           tests = 0;
   int           fails = 0;
   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask
   // Model: an op accepted at edge n finishes (done) after edge n+WIDTH+1, or n+1 for a zero divisor
   int unsigned  edge_n = 0;
   int unsigned  done_edge = 0;
   int unsigned  free_edge = 0;
   bit           have_op = 1'b0;
   bit           started = 1'b0;
   logic [W-1:0] pa = '0, pb = '0;
   logic         m_busy = 1'b0, m_done = 1'b0, m_z = 1'b0;
   logic [W-1:0] m_q = '0, m_r = '0;
   always @(posedge clk) begin
      edge_n++;
      started = 1'b1;
      if (rst) begin
         have_op = 1'b0;
         m_busy = 1'b0;
         m_done = 1'b0;
         m_q = '0;
         m_r = '0;
         m_z = 1'b0;
         free_edge = edge_n + 1;
      end else begin
         m_done = have_op && (edge_n == done_edge);
         if (m_done) begin
            m_z = (pb == 0);
            if (m_z) begin
               m_q = '1;
               m_r = pa;
            end else begin
               m_q = pa / pb;
               m_r = pa % pb;
            end
         end
         if (start && edge_n >= free_edge) begin
            pa = dividend;
            pb = divisor;
            done_edge = edge_n + ((divisor != 0) ? W + 1 : 1);
            free_edge = done_edge + 1;
            have_op = 1'b1;
         end
         m_busy = have_op && (edge_n <= done_edge);
      end
   end
   always @(negedge clk) begin
      if (started) begin
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         chk("quotient", quotient, m_q);
         chk("remainder", remainder, m_r);
         chk("div_by_zero", div_by_zero, m_z);
         if (m_done && pb != 0) begin
            chk("invariant", 32'(quotient) * 32'(pb) + 32'(remainder), 32'(pa));
            chk("rem_lt_div", 32'(remainder < pb), 32'd1);
         end
      end
   end
   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!done) chk("done_timeout", done, 1);
   endtask
   task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] eq,
                     input logic [W-1:0] er, input logic ez, input int elat);
      int n;
      start = 1'b1;
      dividend = a;
      divisor = b;
      @(negedge clk);
      start = 1'b0;
      wait_done(n);
      chk("latency", n, elat);
      chk("lit_q", quotient, eq);
      chk("lit_r", remainder, er);
      chk("lit_dbz", div_by_zero, ez);
   endtask
   task automatic rop(input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      start = 1'b1;
      dividend = a;
      divisor = b;
      @(negedge clk);
      start = 1'b0;
      wait_done(n);
   endtask
   initial begin
      int n;
      int t1;
      repeat (2) @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_q", quotient, 0);
      rst = 1'b0;
      @(negedge clk);
      op(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, W + 1);
      op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, W + 1);
      op(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, W + 1);
      op(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, W + 1);
      op(8'd100, 8'd0, 8'hFF, 8'd100, 1'b1, 1);
      @(negedge clk);
      chk("busy_after_dbz", busy, 0);
      // start raised mid-operation must be ignored
      start = 1'b1;
      dividend = 8'd200;
      divisor = 8'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1;
      dividend = 8'd10;
      divisor = 8'd2;
      @(negedge clk);
      start = 1'b0;
      wait_done(n);
      chk("ignored_lat", n + 3, W + 1);
      chk("ignored_q", quotient, 28);
      chk("ignored_r", remainder, 4);
      // reset mid-operation aborts without a done pulse
      @(negedge clk);
      start = 1'b1;
      dividend = 8'd200;
      divisor = 8'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_q", quotient, 0);
      chk("abort_r", remainder, 0);
      repeat (12) begin
         @(negedge clk);
         chk("abort_no_done", done, 0);
      end
      op(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, W + 1);
      // held start: back-to-back operations
      @(negedge clk);
      start = 1'b1;
      dividend = 8'd77;
      divisor = 8'd5;
      @(negedge clk);
      wait_done(n);
      t1 = int'(edge_n);
      for (int k = 0; k < 3; k++) begin
         chk("held_q", quotient, 15);
         chk("held_r", remainder, 2);
         if (k < 2) begin
            @(negedge clk);
            wait_done(n);
            chk("held_spacing", int'(edge_n) - t1, W + 2);
            t1 = int'(edge_n);
         end
      end
      start = 1'b0;
      @(negedge clk);
      chk("held_idle", busy, 0);
      chk("held_no_restart", done, 0);
      for (int k = 0; k < 1000; k++) begin
         rop(W'($urandom_range(0, 255)), (k % 50 == 0) ? W'(0) : W'($urandom_range(0, 255)));
      end
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
